// File: rtl/apb_pkg.sv
// Shared types and constants for the APB requester: FSM state encoding,
// default widths and the slave index values carried on req_slave.
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

  localparam int unsigned APB_ADDR_W      = 8;
  localparam int unsigned APB_DATA_W      = 8;
  localparam int unsigned APB_TIMEOUT_DEF = 16;

  localparam logic SLV1 = 1'b0;
  localparam logic SLV2 = 1'b1;

endpackage

// File: rtl/apb_timeout_ctr.sv
// Counts ACCESS cycles without PREADY; expired marks the cycle in which the
// count sits at TIMEOUT-1, i.e. the last ACCESS cycle the slave is given.
module apb_timeout_ctr #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Saturates at TIMEOUT so a stray enable can never wrap back to zero.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable && (cnt_q != CNT_W'(TIMEOUT))) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/apb_master.sv
// Single-outstanding APB requester: valid/ready command in, SETUP/ACCESS on
// the bus, one-cycle response strobe out, with a per-transfer timeout.
module apb_master
  import apb_pkg::*;
#(
  parameter int unsigned ADDR_W  = APB_ADDR_W,
  parameter int unsigned DATA_W  = APB_DATA_W,
  parameter int unsigned TIMEOUT = APB_TIMEOUT_DEF
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic              req_slave,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              PSEL1,
  output logic              PSEL2,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [ADDR_W-1:0] PADDR,
  output logic [DATA_W-1:0] PWDATA,
  input  logic [DATA_W-1:0] PRDATA1,
  input  logic [DATA_W-1:0] PRDATA2,
  input  logic              PREADY
);

  // Command handshake: a command transfers on a PCLK edge where both
  // req_valid and req_ready are 1; req_ready never depends on req_valid.

  apb_state_e        state_q, state_d;
  logic              psel1_q, psel1_d;
  logic              psel2_q, psel2_d;
  logic              penable_q, penable_d;
  logic              pwrite_q, pwrite_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;
  logic              to_expired;

  assign req_ready = (state_q == IDLE) && !PRESET;

  apb_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_ctr (
    .clk     (PCLK),
    .rst     (PRESET),
    .clear   (state_q == SETUP),
    .enable  ((state_q == ACCESS) && !PREADY),
    .expired (to_expired)
  );

  always_comb begin
    state_d     = state_q;
    psel1_d     = psel1_q;
    psel2_d     = psel2_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      IDLE: begin
        if (req_valid && req_ready) begin
          pwrite_d  = req_write;
          paddr_d   = req_addr;
          pwdata_d  = req_wdata;
          psel1_d   = (req_slave == SLV1);
          psel2_d   = (req_slave == SLV2);
          penable_d = 1'b0;
          state_d   = SETUP;
        end
      end
      SETUP: begin
        penable_d = 1'b1;
        state_d   = ACCESS;
      end
      ACCESS: begin
        // A completing PREADY takes priority over an expiring count.
        if (PREADY) begin
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = pwrite_q ? '0 : (psel2_q ? PRDATA2 : PRDATA1);
          psel1_d     = 1'b0;
          psel2_d     = 1'b0;
          penable_d   = 1'b0;
          state_d     = IDLE;
        end else if (to_expired) begin
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = '0;
          psel1_d     = 1'b0;
          psel2_d     = 1'b0;
          penable_d   = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        psel1_d   = 1'b0;
        psel2_d   = 1'b0;
        penable_d = 1'b0;
        state_d   = IDLE;
      end
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q     <= IDLE;
      psel1_q     <= 1'b0;
      psel2_q     <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      psel1_q     <= psel1_d;
      psel2_q     <= psel2_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign PSEL1     = psel1_q;
  assign PSEL2     = psel2_q;
  assign PENABLE   = penable_q;
  assign PWRITE    = pwrite_q;
  assign PADDR     = paddr_q;
  assign PWDATA    = pwdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule
